// File: rtl/ula_despacho_if.sv
// Instruction channel of the issue/write-back stage: valid/ready handshake
// carrying the ALU control code and the destination/operand register indices.
interface ula_despacho_if #(
    parameter int BITS_END = 3
);
    logic                instr_valid;
    logic                instr_ready;
    logic [4:0]          instr_op;
    logic [BITS_END-1:0] instr_rd;
    logic [BITS_END-1:0] instr_ra;
    logic [BITS_END-1:0] instr_rb;

    // Issuer side: offers instructions, observes ready.
    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        input  instr_ready
    );

    // Stage side: accepts instructions, drives ready.
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        output instr_ready
    );
endinterface

// File: rtl/ula_despacho.sv
// ula_despacho: issue/write-back stage around a combinational 16-bit ALU.
// Holds an 8-entry register bank (r0 hard-wired to zero), issues one
// instruction at a time through OCIOSO -> LEITURA -> EXECUTA -> ESCRITA,
// writes results back and updates the Z/C/S/O flag register through a
// per-opcode flag mask.
// Optional build macro ULA_DESPACHO_CONTADOR_EN adds instr_contagem, a
// 16-bit wrapping count of completed (written-back) instructions.
module ula_despacho #(
    parameter int BITS_PALAVRA = 16,
    parameter int NUM_REGS     = 8,
    parameter int BITS_END     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    carga_en,
    input  logic [BITS_END-1:0]     carga_rd,
    input  logic [BITS_PALAVRA-1:0] carga_dado,

    ula_despacho_if.slave           instr,

    output logic [4:0]              ula_controle,
    output logic [BITS_PALAVRA-1:0] ula_opA,
    output logic [BITS_PALAVRA-1:0] ula_opB,
    input  logic [BITS_PALAVRA-1:0] ula_resultado,
    input  logic                    ula_Z,
    input  logic                    ula_C,
    input  logic                    ula_S,
    input  logic                    ula_O,

    output logic                    flag_Z,
    output logic                    flag_C,
    output logic                    flag_S,
    output logic                    flag_O,

    output logic                    wb_valid,
    output logic [BITS_END-1:0]     wb_rd,
    output logic [BITS_PALAVRA-1:0] wb_dado,
    output logic                    erro_op,

    input  logic [BITS_END-1:0]     leit_end,
    output logic [BITS_PALAVRA-1:0] leit_dado
`ifdef ULA_DESPACHO_CONTADOR_EN
    ,
    output logic [15:0]             instr_contagem
`endif
);

    typedef enum logic [1:0] {
        OCIOSO,
        LEITURA,
        EXECUTA,
        ESCRITA
    } estado_t;

    estado_t                 estado;
    logic [BITS_PALAVRA-1:0] banco [NUM_REGS];

    // Latched instruction fields
    logic [4:0]              op_q;
    logic [BITS_END-1:0]     rd_q;
    logic [BITS_END-1:0]     ra_q;
    logic [BITS_END-1:0]     rb_q;

    // ALU result and flags captured in EXECUTA, ordered {Z, C, S, O}
    logic [BITS_PALAVRA-1:0] res_q;
    logic [3:0]              ula_flags_q;

    // Architectural flag register, ordered {Z, C, S, O}
    logic [3:0]              flags;

    // Opcodes the ALU does not implement: they still walk the FSM but never
    // write back.
    function automatic logic op_valido(input logic [4:0] op);
        return !(op inside {5'b00010, 5'b00111, [5'b01010:5'b01111]});
    endfunction

    // Which flags each opcode is allowed to update, ordered {Z, C, S, O}.
    function automatic logic [3:0] mascara_flags(input logic [4:0] op);
        if (op inside {5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110})
            return 4'b1111;
        else if (op inside {5'b01000, 5'b01001})
            return 4'b1110;
        else if (op inside {5'b10001, 5'b10010, [5'b10100:5'b11110]})
            return 4'b1010;
        else
            return 4'b0000;
    endfunction

    // Ready only while idle and no direct load competes for the bank port.
    assign instr.instr_ready = (estado == OCIOSO) && !carga_en;

    // Debug read port; r0 always reads zero regardless of storage.
    assign leit_dado = (leit_end == '0) ? '0 : banco[leit_end];

    assign flag_Z = flags[3];
    assign flag_C = flags[2];
    assign flag_S = flags[1];
    assign flag_O = flags[0];

    // Issue FSM, register bank, ALU drive, write-back and flag update.
    // NOTE: every state element here is assigned with <= so all of them update
    // together from values sampled before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            // NOTE: the bank is cleared by reset on purpose; this keeps it in
            // flops rather than a RAM macro, which is fine at eight words.
            for (int i = 0; i < NUM_REGS; i++) begin
                banco[i] <= '0;
            end
            op_q         <= '0;
            rd_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            res_q        <= '0;
            ula_flags_q  <= '0;
            flags        <= '0;
            ula_controle <= '0;
            ula_opA      <= '0;
            ula_opB      <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_dado      <= '0;
            erro_op      <= 1'b0;
`ifdef ULA_DESPACHO_CONTADOR_EN
            instr_contagem <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            erro_op  <= 1'b0;

            case (estado)
                OCIOSO: begin
                    if (carga_en) begin
                        if (carga_rd != '0) begin
                            banco[carga_rd] <= carga_dado;
                        end
                    end else if (instr.instr_valid) begin
                        op_q   <= instr.instr_op;
                        rd_q   <= instr.instr_rd;
                        ra_q   <= instr.instr_ra;
                        rb_q   <= instr.instr_rb;
                        estado <= LEITURA;
                    end
                end

                LEITURA: begin
                    // r0 is never written, so its storage reads zero here.
                    ula_opA      <= banco[ra_q];
                    ula_opB      <= banco[rb_q];
                    ula_controle <= op_q;
                    estado       <= EXECUTA;
                end

                EXECUTA: begin
                    res_q       <= ula_resultado;
                    ula_flags_q <= {ula_Z, ula_C, ula_S, ula_O};
                    estado      <= ESCRITA;
                end

                ESCRITA: begin
                    if (op_valido(op_q)) begin
                        if (rd_q != '0) begin
                            banco[rd_q] <= res_q;
                        end
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_dado  <= res_q;
                        flags    <= (mascara_flags(op_q) & ula_flags_q)
                                  | (~mascara_flags(op_q) & flags);
`ifdef ULA_DESPACHO_CONTADOR_EN
                        instr_contagem <= instr_contagem + 16'd1;
`endif
                    end else begin
                        erro_op <= 1'b1;
                    end
                    estado <= OCIOSO;
                end

                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_despacho.sv
// Directed self-checking bench for ula_despacho, with a small reference
// 16-bit ALU connected on the ula_* ports.
`timescale 1ns/1ps
module tb_ula_despacho;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        carga_en;
    logic [2:0]  carga_rd;
    logic [15:0] carga_dado;
    logic [4:0]  ula_controle;
    logic [15:0] ula_opA, ula_opB, ula_resultado;
    logic        ula_Z, ula_C, ula_S, ula_O;
    logic        flag_Z, flag_C, flag_S, flag_O;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_dado;
    logic        erro_op;
    logic [2:0]  leit_end;
    logic [15:0] leit_dado;
`ifdef ULA_DESPACHO_CONTADOR_EN
    logic [15:0] instr_contagem;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ula_despacho_if #(.BITS_END(3)) instr_bus ();

    ula_despacho dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .carga_en      (carga_en),
        .carga_rd      (carga_rd),
        .carga_dado    (carga_dado),
        .instr         (instr_bus),
        .ula_controle  (ula_controle),
        .ula_opA       (ula_opA),
        .ula_opB       (ula_opB),
        .ula_resultado (ula_resultado),
        .ula_Z         (ula_Z),
        .ula_C         (ula_C),
        .ula_S         (ula_S),
        .ula_O         (ula_O),
        .flag_Z        (flag_Z),
        .flag_C        (flag_C),
        .flag_S        (flag_S),
        .flag_O        (flag_O),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_dado       (wb_dado),
        .erro_op       (erro_op),
        .leit_end      (leit_end),
        .leit_dado     (leit_dado)
`ifdef ULA_DESPACHO_CONTADOR_EN
        ,
        .instr_contagem(instr_contagem)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU for the codes exercised: add, AND, shift-left-by-one and
    // an unimplemented code that returns junk with flags opposite to the held ones.
    always_comb begin
        logic [16:0] soma;
        soma          = {1'b0, ula_opA} + {1'b0, ula_opB};
        ula_resultado = ula_opA;
        ula_C         = 1'b0;
        ula_O         = 1'b0;
        case (ula_controle)
            5'b00000: begin
                ula_resultado = soma[15:0];
                ula_C         = soma[16];
                ula_O         = (ula_opA[15] == ula_opB[15]) && (soma[15] != ula_opA[15]);
            end
            5'b10001: ula_resultado = ula_opA & ula_opB;
            5'b01000: begin
                ula_resultado = {ula_opA[14:0], 1'b0};
                ula_C         = ula_opA[15];
            end
            5'b00111: ula_resultado = 16'hDEAD;
            default:  ula_resultado = ula_opA;
        endcase
        ula_Z = (ula_resultado == 16'h0000);
        ula_S = ula_resultado[15];
        if (ula_controle == 5'b00111) begin
            ula_Z = 1'b1;
            ula_C = 1'b0;
            ula_S = 1'b1;
            ula_O = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic carregar(input logic [2:0] rd, input logic [15:0] v);
        carga_en   = 1'b1;
        carga_rd   = rd;
        carga_dado = v;
        tick();
        carga_en   = 1'b0;
    endtask

    task automatic ler(input string tag, input logic [2:0] a, input logic [15:0] exp);
        leit_end = a;
        #1;
        check(tag, leit_dado, exp);
    endtask

    // Issue one instruction and check the exact write-back / error timing.
    task automatic executar(input string tag, input logic [4:0] op, input logic [2:0] rd,
                            input logic [2:0] ra, input logic [2:0] rb,
                            input logic esp_wb, input logic [15:0] esp_dado,
                            input logic [3:0] esp_flags);
        int k;
        instr_bus.instr_op    = op;
        instr_bus.instr_rd    = rd;
        instr_bus.instr_ra    = ra;
        instr_bus.instr_rb    = rb;
        instr_bus.instr_valid = 1'b1;
        #1;
        k = 0;
        while (!instr_bus.instr_ready && k < 20) begin
            tick();
            k++;
        end
        if (!instr_bus.instr_ready) check({tag, "_ready_timeout"}, 0, 1);
        tick();                                   // accepted at edge T
        instr_bus.instr_valid = 1'b0;
        tick();                                   // T+1
        tick();                                   // T+2
        check({tag, "_wb_early"}, wb_valid, 1'b0);
        tick();                                   // T+3
        check({tag, "_wb_valid"}, wb_valid, esp_wb);
        check({tag, "_erro_op"}, erro_op, !esp_wb);
        if (esp_wb) begin
            check({tag, "_wb_rd"}, wb_rd, rd);
            check({tag, "_wb_dado"}, wb_dado, esp_dado);
        end
        check({tag, "_flags"}, {flag_Z, flag_C, flag_S, flag_O}, esp_flags);
        check({tag, "_ready_after"}, instr_bus.instr_ready, 1'b1);
        tick();                                   // T+4
        check({tag, "_pulse_end"}, {wb_valid, erro_op}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                 = 1'b0;
        carga_en              = 1'b0;
        carga_rd              = '0;
        carga_dado            = '0;
        leit_end              = '0;
        instr_bus.instr_valid = 1'b0;
        instr_bus.instr_op    = '0;
        instr_bus.instr_rd    = '0;
        instr_bus.instr_ra    = '0;
        instr_bus.instr_rb    = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_ready", instr_bus.instr_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_flags", {flag_Z, flag_C, flag_S, flag_O}, 4'b0000);
        check("rst_ula_opA", ula_opA, 16'h0000);
        ler("rst_r1", 3'd1, 16'h0000);

        // Add overflowing into the sign bit
        carregar(3'd1, 16'h7FFF);
        carregar(3'd2, 16'h0001);
        ler("load_r1", 3'd1, 16'h7FFF);
        executar("add", 5'b00000, 3'd3, 3'd1, 3'd2, 1'b1, 16'h8000, 4'b0011);
        ler("add_r3", 3'd3, 16'h8000);

        // AND: only Z and S written, C=0 and O=1 kept
        executar("and", 5'b10001, 3'd4, 3'd1, 3'd2, 1'b1, 16'h0001, 4'b0001);
        ler("and_r4", 3'd4, 16'h0001);

        // Shift left: Z C S written, O kept
        carregar(3'd5, 16'h8001);
        executar("shl", 5'b01000, 3'd6, 3'd5, 3'd0, 1'b1, 16'h0002, 4'b0101);
        ler("shl_r6", 3'd6, 16'h0002);
`ifdef ULA_DESPACHO_CONTADOR_EN
        check("cnt_before_err", instr_contagem, 16'd3);
`endif

        // Unsupported opcode: erro_op only, nothing written
        executar("bad_op", 5'b00111, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 4'b0101);
        ler("bad_op_r7", 3'd7, 16'h0000);
`ifdef ULA_DESPACHO_CONTADOR_EN
        check("cnt_after_err", instr_contagem, 16'd3);
`endif

        // Load and instruction together: load wins, instruction next cycle
        carga_en              = 1'b1;
        carga_rd              = 3'd7;
        carga_dado            = 16'h1234;
        instr_bus.instr_op    = 5'b00000;
        instr_bus.instr_rd    = 3'd0;
        instr_bus.instr_ra    = 3'd1;
        instr_bus.instr_rb    = 3'd2;
        instr_bus.instr_valid = 1'b1;
        #1;
        check("prio_ready_low", instr_bus.instr_ready, 1'b0);
        tick();
        carga_en = 1'b0;
        #1;
        check("prio_ready_back", instr_bus.instr_ready, 1'b1);
        ler("prio_r7", 3'd7, 16'h1234);
        executar("add_r0", 5'b00000, 3'd0, 3'd1, 3'd2, 1'b1, 16'h8000, 4'b0011);
        ler("r0_zero", 3'd0, 16'h0000);
`ifdef ULA_DESPACHO_CONTADOR_EN
        check("cnt_r0", instr_contagem, 16'd4);
`endif

        // Reset during EXECUTA aborts the instruction and clears everything
        instr_bus.instr_op    = 5'b00000;
        instr_bus.instr_rd    = 3'd5;
        instr_bus.instr_ra    = 3'd1;
        instr_bus.instr_rb    = 3'd2;
        instr_bus.instr_valid = 1'b1;
        tick();                                   // accepted
        instr_bus.instr_valid = 1'b0;
        tick();                                   // now in EXECUTA
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", instr_bus.instr_ready, 1'b1);
        check("mid_rst_wb", wb_valid, 1'b0);
        check("mid_rst_flags", {flag_Z, flag_C, flag_S, flag_O}, 4'b0000);
        check("mid_rst_ula", {ula_controle, ula_opA}, 21'h0);
        tick();
        check("mid_rst_no_wb", {wb_valid, erro_op}, 2'b00);
        for (int i = 0; i < 8; i++) begin
            ler($sformatf("mid_rst_r%0d", i), 3'(i), 16'h0000);
        end
`ifdef ULA_DESPACHO_CONTADOR_EN
        check("cnt_rst", instr_contagem, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ula_despacho.md
Name: ula_despacho

Overview:
- Issue/write-back stage wrapped around the 16-bit ALU (5-bit control code; flags Z, C, S, O).
- Holds an 8-entry register bank and accepts one ALU instruction at a time over a valid/ready handshake.
- Drives the ALU operands and control code, then captures the result and flags.
- Writes the result back to the bank and updates a flag register using a per-opcode flag mask.

Parameters:
- BITS_PALAVRA, 16, data word width
- NUM_REGS, 8, register bank depth
- BITS_END, 3, register address width (log2 NUM_REGS)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- carga_en  in  1  direct register load strobe
- carga_rd  in  BITS_END  load destination
- carga_dado  in  BITS_PALAVRA  load value
- instr_valid  in  1  instruction offered
- instr_ready  out  1  stage can accept
- instr_op  in  5  ALU control code
- instr_rd / instr_ra / instr_rb  in  BITS_END each  destination / operand A / operand B
- ula_controle  out  5  to ALU control
- ula_opA / ula_opB  out  BITS_PALAVRA  to ALU operands
- ula_resultado  in  BITS_PALAVRA  from ALU
- ula_Z / ula_C / ula_S / ula_O  in  1  ALU flags
- flag_Z / flag_C / flag_S / flag_O  out  1  registered flag register
- wb_valid  out  1  one-cycle write-back pulse
- wb_rd  out  BITS_END  write-back address
- wb_dado  out  BITS_PALAVRA  write-back value
- erro_op  out  1  one-cycle pulse on an unsupported opcode
- leit_end  in  BITS_END  debug read address
- leit_dado  out  BITS_PALAVRA  combinational debug read; r0 always reads 0

Behaviour:
- Clock and reset:
  - One clock: clk.
  - rst_n is synchronous, active-low, sampled on the rising edge.
  - Reset clears all registers, flags, ula_* outputs, wb_*, erro_op and the FSM (to OCIOSO).
  - Reset mid-instruction aborts it: no write-back, no flag update.
- Register r0 reads 0; writes to r0 (load or write-back) are discarded, but wb_valid still pulses.
- FSM states:
  - OCIOSO:
    - instr_ready=1 unless carga_en=1.
    - carga_en has priority: the bank is written this edge, instr_ready=0, and no instruction is accepted.
    - On instr_valid && instr_ready: latch op/rd/ra/rb, go to LEITURA.
  - LEITURA:
    - Register ula_opA=R[ra], ula_opB=R[rb], ula_controle=op; go to EXECUTA.
    - carga_en is ignored in every state except OCIOSO.
  - EXECUTA:
    - The ALU is combinational.
    - Capture ula_resultado and ula_Z/C/S/O into internal holding registers; go to ESCRITA.
  - ESCRITA:
    - Valid opcode: write the result to R[rd], pulse wb_valid with wb_rd/wb_dado, apply the flag mask.
    - Go to OCIOSO.
- Latency: accepted at edge T; wb_valid is high during cycle T+3; the next accept is possible at edge T+4.
- ula_* outputs hold their last values in OCIOSO.
- Flag mask (masked flags are written; unmasked flags keep their value):
  - 00000, 00001, 00011, 00100, 00101, 00110: Z C S O
  - 01000, 01001: Z C S
  - 10001, 10010, 10100–11110: Z S
  - 10000, 10011, 11111: none
- Unsupported codes 00010, 00111, 01010–01111:
  - The instruction still walks through the FSM.
  - In ESCRITA: no bank write, no wb_valid, no flag change; erro_op pulses instead.
- Hazards:
  - Instructions are serialized, so no hazard exists.
  - Operands are read in LEITURA, so a prior write-back is always visible.
- Bounds:
  - Addresses are exactly BITS_END wide, so no out-of-range access is possible.
  - Arithmetic width is set by the ALU; this block never modifies result bits.

Optional Feature:
- Macro: ULA_DESPACHO_CONTADOR_EN.
- When defined:
  - Adds output instr_contagem (16 bits): a count of completed instructions (wb_valid pulses).
  - Cleared by reset; wraps 0xFFFF→0x0000.
  - erro_op instructions are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- The bench instantiates a correct 16-bit ALU on the ula_* ports for every scenario.
- Load r1=0x7FFF, r2=0x0001; op 00000, rd=3, ra=1, rb=2 → wb_valid at T+3, wb_dado=0x8000, flags Z=0 C=0 S=1 O=1; leit_end=3 reads 0x8000.
- Then op 10001 (AND), rd=4, ra=1, rb=2 → wb_dado=0x0001; Z=0, S=0; C=0 and O=1 unchanged from the previous instruction.
- Load r5=0x8001; op 01000 (shift left), rd=6, ra=5 → wb_dado=0x0002, C=1, S=0, Z=0; O unchanged.
- Opcode 00111 → no wb_valid, erro_op pulses at T+3, flags and bank unchanged; with ULA_DESPACHO_CONTADOR_EN the count is unchanged.
- instr_valid and carga_en high together in OCIOSO → instr_ready=0, load wins, instruction accepted next cycle. Op 00000 with rd=0 → wb_valid pulses and r0 still reads 0.
- Assert rst_n=0 during EXECUTA → next cycle state is OCIOSO, no wb_valid, flags=0, every bank entry reads 0.
